// File: rtl/execute_stage_mc.sv
// Execute stage with EX/MEM register: forwarding, single-cycle ALU, iterative
// unsigned MUL/DIVU/REMU with pipeline stall, and registered BEQ/BNE resolution.
module execute_stage_mc #(
  parameter int unsigned DW  = 32,
  parameter int unsigned RW  = 5,
  parameter int unsigned SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [3:0]     id_op,
  input  logic [DW-1:0]  id_a,
  input  logic [DW-1:0]  id_b,
  input  logic [DW-1:0]  id_imm,
  input  logic           id_use_imm,
  input  logic [SHW-1:0] id_shamt,
  input  logic           id_sh_var,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic [RW-1:0]  id_rd,
  input  logic           id_wr,
  input  logic [1:0]     id_br,
  input  logic [DW-1:0]  id_pc,
  input  logic [RW-1:0]  wb_rd,
  input  logic           wb_wr,
  input  logic [DW-1:0]  wb_data,
  output logic           ex_busy,
  output logic           mem_valid,
  output logic [DW-1:0]  mem_result,
  output logic [DW-1:0]  mem_store,
  output logic [RW-1:0]  mem_rd,
  output logic           mem_wr,
  output logic           mem_zero,
  output logic           br_taken,
  output logic [DW-1:0]  br_target
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [SHW-1:0] count;
  logic [DW-1:0]  mcA;      // multiplicand (MUL) or dividend/quotient (DIVU/REMU)
  logic [DW-1:0]  mcB;      // multiplier (MUL) or divisor (DIVU/REMU)
  logic [DW-1:0]  mcAcc;    // product accumulator or partial remainder
  logic [3:0]     mcOp;
  logic [RW-1:0]  mcRd;
  logic           mcWr;
  logic [DW-1:0]  mcStore;

  logic [DW-1:0]  fwdA;
  logic [DW-1:0]  fwdB;
  logic [DW-1:0]  opB;
  logic [SHW-1:0] shAmt;
  logic [DW-1:0]  aluRes;
  logic           isMulti;
  logic           isBranch;
  logic           brCond;
  logic [DW:0]    remShift;
  logic [DW:0]    remDiff;
  logic           takeSub;
  logic [DW-1:0]  mcResult;

  // Operand forwarding: EX/MEM has priority over WB; register 0 never forwards.
  always_comb begin
    fwdA = id_a;
    if (id_rs != '0) begin
      if (mem_wr && (mem_rd == id_rs))     fwdA = mem_result;
      else if (wb_wr && (wb_rd == id_rs))  fwdA = wb_data;
    end
    fwdB = id_b;
    if (id_rt != '0) begin
      if (mem_wr && (mem_rd == id_rt))     fwdB = mem_result;
      else if (wb_wr && (wb_rd == id_rt))  fwdB = wb_data;
    end
  end

  // Single-cycle ALU; shifts operate on B, opcodes 13-15 behave as ADD.
  always_comb begin
    opB    = id_use_imm ? id_imm : fwdB;
    shAmt  = id_sh_var ? fwdA[SHW-1:0] : id_shamt;
    aluRes = fwdA + opB;
    case (id_op)
      OP_SUB:  aluRes = fwdA - opB;
      OP_AND:  aluRes = fwdA & opB;
      OP_OR:   aluRes = fwdA | opB;
      OP_XOR:  aluRes = fwdA ^ opB;
      OP_NOR:  aluRes = ~(fwdA | opB);
      OP_SLT:  aluRes = {{(DW-1){1'b0}}, ($signed(fwdA) < $signed(opB))};
      OP_SLL:  aluRes = opB << shAmt;
      OP_SRL:  aluRes = opB >> shAmt;
      OP_SRA:  aluRes = $unsigned($signed(opB) >>> shAmt);
      default: aluRes = fwdA + opB;
    endcase
  end

  // Decode, branch condition, restoring-divide step and stall request.
  always_comb begin
    isMulti  = (id_op == OP_MUL) || (id_op == OP_DIVU) || (id_op == OP_REMU);
    isBranch = (id_br == 2'b01) || (id_br == 2'b10);
    brCond   = ((id_br == 2'b01) && (fwdA == fwdB)) || ((id_br == 2'b10) && (fwdA != fwdB));
    remShift = {mcAcc, mcA[DW-1]};
    remDiff  = remShift - {1'b0, mcB};
    // A zero divisor always subtracts, giving all-ones quotient and remainder = dividend.
    takeSub  = (mcB == '0) || !remDiff[DW];
    mcResult = (mcOp == OP_DIVU) ? mcA : mcAcc;
    ex_busy  = ((state == IDLE) && id_valid && isMulti) || (state == BUSY);
  end

  // Multi-cycle unit: latch operands, iterate DW steps, then hand result to EX/MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      mcA     <= '0;
      mcB     <= '0;
      mcAcc   <= '0;
      mcOp    <= '0;
      mcRd    <= '0;
      mcWr    <= 1'b0;
      mcStore <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (id_valid && isMulti) begin
            state   <= BUSY;
            count   <= '0;
            mcA     <= fwdA;
            mcB     <= fwdB;
            mcAcc   <= '0;
            mcOp    <= id_op;
            mcRd    <= id_rd;
            mcWr    <= id_wr;
            mcStore <= fwdB;
          end
        end
        BUSY: begin
          if (mcOp == OP_MUL) begin
            if (mcB[0]) mcAcc <= mcAcc + mcA;
            mcA <= mcA << 1;
            mcB <= mcB >> 1;
          end else begin
            mcAcc <= takeSub ? remDiff[DW-1:0] : remShift[DW-1:0];
            mcA   <= {mcA[DW-2:0], takeSub};
          end
          count <= count + 1'b1;
          if (count == SHW'(DW - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // EX/MEM register and registered branch outcome; bubbles hold the data fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      mem_result <= '0;
      mem_store  <= '0;
      mem_rd     <= '0;
      mem_wr     <= 1'b0;
      mem_zero   <= 1'b0;
      br_taken   <= 1'b0;
      br_target  <= '0;
    end else begin
      br_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (id_valid && !isMulti) begin
            mem_valid  <= 1'b1;
            mem_result <= aluRes;
            mem_zero   <= (aluRes == '0);
            mem_store  <= fwdB;
            mem_rd     <= id_rd;
            mem_wr     <= id_wr && !isBranch;
            br_taken   <= brCond;
            br_target  <= id_pc + (id_imm << 2);
          end else begin
            mem_valid <= 1'b0;
            mem_wr    <= 1'b0;
          end
        end
        DONE: begin
          mem_valid  <= 1'b1;
          mem_result <= mcResult;
          mem_zero   <= (mcResult == '0);
          mem_store  <= mcStore;
          mem_rd     <= mcRd;
          mem_wr     <= mcWr;
        end
        default: begin
          mem_valid <= 1'b0;
          mem_wr    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Self-checking bench for execute_stage_mc: directed vectors, literal expectations
// and a behavioural model compared against the DUT on every falling edge.
module tb_execute_stage_mc;

  localparam int DW = 32;

  logic        clk, rst;
  logic        id_valid;
  logic [3:0]  id_op;
  logic [31:0] id_a, id_b, id_imm, id_pc, wb_data;
  logic        id_use_imm, id_sh_var, id_wr, wb_wr;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd, wb_rd;
  logic [1:0]  id_br;
  logic        ex_busy, mem_valid, mem_wr, mem_zero, br_taken;
  logic [31:0] mem_result, mem_store, br_target;
  logic [4:0]  mem_rd;

  int checks = 0;
  int failures = 0;
  bit cmpOn = 1'b0;

  execute_stage_mc #(.DW(32), .RW(5), .SHW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_a(id_a), .id_b(id_b),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_shamt(id_shamt), .id_sh_var(id_sh_var),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_wr(id_wr), .id_br(id_br),
    .id_pc(id_pc), .wb_rd(wb_rd), .wb_wr(wb_wr), .wb_data(wb_data), .ex_busy(ex_busy),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_store(mem_store),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_zero(mem_zero), .br_taken(br_taken),
    .br_target(br_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        eValid, eWr, eZero, eBrTaken;
  logic [31:0] eResult, eStore, eBrTarget;
  logic [4:0]  eRd;
  int          mcLeft;  // edges still to go before a multi-cycle result lands
  logic [31:0] mcRes, mcStoreM;
  logic [4:0]  mcRdM;
  logic        mcWrM;

  function automatic logic [31:0] fwdVal(input logic [4:0] r, input logic [31:0] v);
    if (r == 5'd0) return v;
    if (eWr && eRd == r) return eResult;
    if (wb_wr && wb_rd == r) return wb_data;
    return v;
  endfunction

  function automatic bit isMc(input logic [3:0] op);
    return (op >= 4'd10) && (op <= 4'd12);
  endfunction

  function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input int sh);
    case (op)
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return b << sh;
      4'd8: return b >> sh;
      4'd9: return $signed(b) >>> sh;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] mcRef(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    if (op == 4'd10) return p[31:0];
    if (op == 4'd11) return (b == 0) ? 32'hFFFF_FFFF : a / b;
    return (b == 0) ? a : a % b;
  endfunction

  function automatic logic [31:0] modelAlu();
    logic [31:0] fa, fb;
    int sh;
    fa = fwdVal(id_rs, id_a);
    fb = id_use_imm ? id_imm : fwdVal(id_rt, id_b);
    sh = id_sh_var ? int'(fa[4:0]) : int'(id_shamt);
    return aluRef(id_op, fa, fb, sh);
  endfunction

  function automatic bit modelBr();
    logic [31:0] fa, fb;
    fa = fwdVal(id_rs, id_a);
    fb = fwdVal(id_rt, id_b);
    return ((id_br == 2'b01) && (fa == fb)) || ((id_br == 2'b10) && (fa != fb));
  endfunction

  function automatic bit modelBusy();
    return (mcLeft > 1) || (mcLeft == 0 && id_valid && isMc(id_op));
  endfunction

  // Model update on each rising edge (async reset mirrors the stage's reset).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eValid <= 0; eWr <= 0; eZero <= 0; eBrTaken <= 0;
      eResult <= 0; eStore <= 0; eBrTarget <= 0; eRd <= 0;
      mcLeft <= 0; mcRes <= 0; mcStoreM <= 0; mcRdM <= 0; mcWrM <= 0;
    end else if (mcLeft > 1) begin
      mcLeft <= mcLeft - 1; eValid <= 0; eWr <= 0; eBrTaken <= 0;
    end else if (mcLeft == 1) begin
      mcLeft <= 0; eValid <= 1; eResult <= mcRes; eZero <= (mcRes == 0);
      eStore <= mcStoreM; eRd <= mcRdM; eWr <= mcWrM; eBrTaken <= 0;
    end else begin
      eBrTaken <= 0;
      if (id_valid && isMc(id_op)) begin
        mcLeft   <= DW + 1;
        mcRes    <= mcRef(id_op, fwdVal(id_rs, id_a), fwdVal(id_rt, id_b));
        mcStoreM <= fwdVal(id_rt, id_b);
        mcRdM    <= id_rd;
        mcWrM    <= id_wr;
        eValid <= 0; eWr <= 0;
      end else if (id_valid) begin
        eValid    <= 1;
        eResult   <= modelAlu();
        eZero     <= (modelAlu() == 0);
        eStore    <= fwdVal(id_rt, id_b);
        eRd       <= id_rd;
        eWr       <= id_wr && !(id_br == 2'b01 || id_br == 2'b10);
        eBrTaken  <= modelBr();
        eBrTarget <= id_pc + (id_imm << 2);
      end else begin
        eValid <= 0; eWr <= 0;
      end
    end
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (cmpOn) begin
      chk("cmp_ex_busy", ex_busy, modelBusy());
      chk("cmp_mem_valid", mem_valid, eValid);
      chk("cmp_mem_result", mem_result, eResult);
      chk("cmp_mem_store", mem_store, eStore);
      chk("cmp_mem_rd", mem_rd, eRd);
      chk("cmp_mem_wr", mem_wr, eWr);
      chk("cmp_mem_zero", mem_zero, eZero);
      chk("cmp_br_taken", br_taken, eBrTaken);
      chk("cmp_br_target", br_target, eBrTarget);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic wr);
    id_valid = 1; id_op = op; id_a = a; id_b = b; id_rs = rs; id_rt = rt; id_rd = rd;
    id_wr = wr; id_imm = 0; id_use_imm = 0; id_shamt = 0; id_sh_var = 0; id_br = 0;
    id_pc = 0; wb_rd = 0; wb_wr = 0; wb_data = 0;
  endtask

  task automatic runMc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input string name);
    int busyCyc;
    int badBubble;
    bit done;
    busyCyc = 0; badBubble = 0; done = 0;
    drive(op, a, b, 5'd0, 5'd0, 5'd8, 1'b1);
    #1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (!ex_busy) done = 1;
      else begin
        busyCyc++;
        tick();
        if (mem_valid) badBubble++;
      end
    end
    chk({name, "_finished"}, done, 1);
    chk({name, "_busy_cycles"}, busyCyc, 33);
    chk({name, "_bubbles_valid"}, badBubble, 0);
    tick();
    id_valid = 0;
    chk({name, "_result"}, mem_result, expv);
    chk({name, "_valid"}, mem_valid, 1);
    chk({name, "_rd"}, mem_rd, 8);
  endtask

  logic [3:0]  tOp [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd9,
                            4'd7, 4'd14};
  logic [31:0] tA  [12] = '{32'd3, 32'hF0F0, 32'hF0F0, 32'hFF, 32'd0, 32'hFFFF_FFFF, 32'd1,
                            32'd0, 32'd0, 32'd0, 32'd8, 32'd2};
  logic [31:0] tB  [12] = '{32'd5, 32'hFF00, 32'h0F00, 32'h0F, 32'd0, 32'd1, 32'hFFFF_FFFF,
                            32'd1, 32'h8000_0000, 32'h8000_0000, 32'hFF, 32'd3};
  logic [4:0]  tSh [12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd4, 5'd4,
                            5'd0, 5'd0};
  logic        tSv [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b1, 1'b0};
  logic [31:0] tExp[12] = '{32'hFFFF_FFFE, 32'hF000, 32'hFFF0, 32'hF0, 32'hFFFF_FFFF, 32'd1,
                            32'd0, 32'h8000_0000, 32'h0800_0000, 32'hF800_0000, 32'hFF00,
                            32'd5};

  initial begin
    rst = 0;
    drive(4'd0, 0, 0, 0, 0, 0, 0);
    id_valid = 0;
    #2 rst = 1;
    #1 cmpOn = 1;
    chk("reset_mem_valid", mem_valid, 0);
    chk("reset_mem_result", mem_result, 0);
    chk("reset_ex_busy", ex_busy, 0);
    chk("reset_mem_zero", mem_zero, 0);
    chk("reset_br_taken", br_taken, 0);
    tick();
    rst = 0;

    // ADD without forwarding
    drive(4'd0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd4, 1'b1);
    tick();
    chk("add_result", mem_result, 12);
    chk("add_valid", mem_valid, 1);
    chk("add_zero", mem_zero, 0);
    chk("add_rd", mem_rd, 4);

    // Forwarding: MEM over WB, WB alone, B operand, register 0
    drive(4'd0, 32'h10, 32'h0, 5'd0, 5'd0, 5'd3, 1'b1);
    tick();
    drive(4'd0, 32'h99, 32'h1, 5'd3, 5'd0, 5'd5, 1'b1);
    wb_rd = 5'd3; wb_wr = 1; wb_data = 32'h20;
    tick();
    chk("fwd_mem_prio", mem_result, 32'h11);
    drive(4'd0, 32'h99, 32'h0, 5'd3, 5'd0, 5'd7, 1'b1);
    wb_rd = 5'd3; wb_wr = 1; wb_data = 32'h20;
    tick();
    chk("fwd_wb", mem_result, 32'h20);
    drive(4'd0, 32'd10, 32'h999, 5'd0, 5'd7, 5'd8, 1'b1);
    tick();
    chk("fwd_b_mem", mem_result, 32'h2A);
    chk("fwd_b_store", mem_store, 32'h20);
    drive(4'd0, 32'd0, 32'h55, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    drive(4'd0, 32'd1, 32'd2, 5'd0, 5'd0, 5'd7, 1'b1);
    wb_rd = 5'd0; wb_wr = 1; wb_data = 32'h77;
    tick();
    chk("fwd_r0_none", mem_result, 3);

    // Single-cycle operation table
    for (int i = 0; i < 12; i++) begin
      drive(tOp[i], tA[i], tB[i], 5'd0, 5'd0, 5'd7, 1'b1);
      id_shamt = tSh[i]; id_sh_var = tSv[i];
      tick();
      chk($sformatf("alu_vec%0d", i), mem_result, tExp[i]);
    end
    drive(4'd0, 32'd10, 32'h999, 5'd0, 5'd0, 5'd7, 1'b1);
    id_use_imm = 1; id_imm = 32'hFFFF_FFFF;
    tick();
    chk("imm_result", mem_result, 9);
    chk("imm_store", mem_store, 32'h999);
    drive(4'd1, 32'd5, 32'd5, 5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    chk("sub_zero_flag", mem_zero, 1);

    // Branches
    drive(4'd0, 32'd4, 32'd4, 5'd0, 5'd0, 5'd9, 1'b1);
    id_br = 2'b01; id_pc = 32'h100; id_imm = 32'd3;
    tick();
    id_valid = 0;
    chk("beq_taken", br_taken, 1);
    chk("beq_target", br_target, 32'h10C);
    chk("beq_mem_wr", mem_wr, 0);
    tick();
    chk("beq_pulse_end", br_taken, 0);
    drive(4'd0, 32'd4, 32'd5, 5'd0, 5'd0, 5'd9, 1'b1);
    id_br = 2'b10; id_pc = 32'h200; id_imm = 32'hFFFF_FFFF;
    tick();
    chk("bne_taken", br_taken, 1);
    chk("bne_target", br_target, 32'h1FC);
    drive(4'd0, 32'd4, 32'd4, 5'd0, 5'd0, 5'd9, 1'b1);
    id_br = 2'b10;
    tick();
    id_valid = 0;
    chk("bne_not_taken", br_taken, 0);
    tick();

    // Multi-cycle operations
    runMc(4'd10, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, "mul");
    runMc(4'd11, 32'd100, 32'd7, 32'd14, "divu");
    runMc(4'd12, 32'd100, 32'd7, 32'd2, "remu");
    runMc(4'd11, 32'd12345, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    runMc(4'd12, 32'd9, 32'd0, 32'd9, "remu_by0");
    tick();

    // Reset in the middle of BUSY
    drive(4'd10, 32'd7, 32'd9, 5'd0, 5'd0, 5'd8, 1'b1);
    tick();
    repeat (10) tick();
    chk("pre_reset_busy", ex_busy, 1);
    #1;
    rst = 1; id_valid = 0;
    #1;
    chk("rst_ex_busy", ex_busy, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_result", mem_result, 0);
    chk("rst_mem_store", mem_store, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_zero", mem_zero, 0);
    chk("rst_br_target", br_target, 0);
    tick();
    rst = 0;
    drive(4'd0, 32'd1, 32'd2, 5'd0, 5'd0, 5'd3, 1'b1);
    #1;
    chk("post_rst_not_busy", ex_busy, 0);
    tick();
    id_valid = 0;
    chk("post_rst_add", mem_result, 3);
    chk("post_rst_valid", mem_valid, 1);
    tick();
    tick();
    cmpOn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
